// File: rtl/crc_pkg.sv
// Shared CRC-32 definitions used by the generator and checker blocks.
package crc_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int CRC_W_DEF  = 32;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } chk_state_t;

endpackage

// File: rtl/crc_32_div_step.sv
// One bit of polynomial long division: shift the next codeword bit into the
// remainder and reduce by POLY when the bit falling off the top is set.
module crc_32_div_step #(
  parameter int CRC_W = 32,
  parameter logic [CRC_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic [CRC_W-1:0] r,
  input  logic             b,
  output logic [CRC_W-1:0] r_next
);

  logic [CRC_W-1:0] shifted;

  assign shifted = {r[CRC_W-2:0], b};

  generate
    for (genvar gi = 0; gi < CRC_W; gi++) begin : g_bit
      assign r_next[gi] = shifted[gi] ^ (r[CRC_W-1] & POLY[gi]);
    end
  endgenerate

endmodule

// File: rtl/crc_32_check.sv
// Serial CRC-32 checker: divides a {data, crc} codeword by POLY one bit per
// clock and reports the syndrome, pass/fail, recovered data and error count.
module crc_32_check
  import crc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CRC_W  = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY = CRC32_POLY,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W+CRC_W-1:0] code_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    crc_ok,
  output logic [CRC_W-1:0]        syndrome,
  output logic [DATA_W-1:0]       data_out,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int CODE_W   = DATA_W + CRC_W;
  localparam int CNT_BITS = $clog2(CODE_W);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(CODE_W - 1);

  chk_state_t           state_reg;
  logic [CODE_W-1:0]    shift_reg;
  logic [CRC_W-1:0]     r_reg;
  logic [CRC_W-1:0]     r_next;
  logic [CNT_BITS-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0]    data_cap_reg;
  logic                 crc_ok_reg;
  logic [CRC_W-1:0]     syndrome_reg;
  logic [DATA_W-1:0]    data_out_reg;
  logic [CNT_W-1:0]     err_cnt_reg;

  crc_32_div_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_div_step (
    .r      (r_reg),
    .b      (shift_reg[CODE_W-1]),
    .r_next (r_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      r_reg        <= '0;
      bit_cnt_reg  <= '0;
      data_cap_reg <= '0;
      crc_ok_reg   <= 1'b0;
      syndrome_reg <= '0;
      data_out_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg    <= code_in;
            data_cap_reg <= code_in[CODE_W-1 -: DATA_W];
            r_reg        <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg   <= shift_reg << 1;
          r_reg       <= r_next;
          bit_cnt_reg <= bit_cnt_reg + CNT_BITS'(1);
          // Results are latched from the step output so the last bit is included.
          if (bit_cnt_reg == LAST_BIT) begin
            state_reg    <= DONE;
            syndrome_reg <= r_next;
            crc_ok_reg   <= (r_next == '0);
            data_out_reg <= data_cap_reg;
            if ((r_next != '0) && (err_cnt_reg != {CNT_W{1'b1}})) begin
              err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign crc_ok    = crc_ok_reg;
  assign syndrome  = syndrome_reg;
  assign data_out  = data_out_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_crc_32_check.sv
// Directed bench for crc_32_check: vector table plus backpressure, mid-shift
// reset and counter saturation sequences (second instance with a 2-bit counter).
module tb_crc_32_check;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] code_in;
  logic        out_valid;
  logic        out_ready;
  logic        crc_ok;
  logic [31:0] syndrome;
  logic [4:0]  data_out;
  logic [15:0] err_cnt;

  logic        s2_in_ready;
  logic        s2_out_valid;
  logic        s2_crc_ok;
  logic [31:0] s2_syndrome;
  logic [4:0]  s2_data_out;
  logic [1:0]  s2_err_cnt;

  int errors = 0;
  int checks = 0;

  crc_32_check dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code_in   (code_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .crc_ok    (crc_ok),
    .syndrome  (syndrome),
    .data_out  (data_out),
    .err_cnt   (err_cnt)
  );

  crc_32_check #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s2_in_ready),
    .code_in   (code_in),
    .out_valid (s2_out_valid),
    .out_ready (out_ready),
    .crc_ok    (s2_crc_ok),
    .syndrome  (s2_syndrome),
    .data_out  (s2_data_out),
    .err_cnt   (s2_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [36:0] code;
    logic        ok;
    logic [31:0] syn;
    logic [4:0]  data;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } vec_t;

  vec_t vecs[6];

  // Accept one codeword, time the result, check it, then consume it.
  task automatic send(input logic [36:0] code, input logic ok, input logic [31:0] syn,
                      input logic [4:0] data, input logic [15:0] cnt, input logic [1:0] cnt2);
    int n;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    code_in  = code;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("latency", 64'(n), 64'd37);
    check("crc_ok", crc_ok, ok);
    check("syndrome", syndrome, syn);
    check("data_out", data_out, data);
    check("err_cnt", err_cnt, cnt);
    check("err_cnt_sat", s2_err_cnt, cnt2);
    $display("txn code=%h ok=%0b syn=%h data=%h cnt=%0d cnt2=%0d lat=%0d",
             code, crc_ok, syndrome, data_out, err_cnt, s2_err_cnt, n);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake_valid", out_valid, 1'b0);
    check("idle_after_handshake_ready", in_ready, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] syn_hold;
    logic        ok_hold;
    logic [4:0]  data_hold;
    int n;
    bit seen;

    rst = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b0;

    vecs[0] = '{37'h19_6ED82B7F, 1'b1, 32'h00000000, 5'h19, 16'd0, 2'd0};
    vecs[1] = '{37'h19_6ED82B7E, 1'b0, 32'h00000001, 5'h19, 16'd1, 2'd1};
    vecs[2] = '{37'h18_6ED82B7F, 1'b0, 32'h04C11DB7, 5'h18, 16'd2, 2'd2};
    vecs[3] = '{37'h09_6ED82B7F, 1'b0, 32'h4C11DB70, 5'h09, 16'd3, 2'd3};
    vecs[4] = '{37'h00_00000000, 1'b1, 32'h00000000, 5'h00, 16'd3, 2'd3};
    vecs[5] = '{37'h19_6ED82B7C, 1'b0, 32'h00000003, 5'h19, 16'd4, 2'd3};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_err_cnt", err_cnt, 16'd0);
    check("rst_syndrome", syndrome, 32'd0);
    check("rst_crc_ok", crc_ok, 1'b0);
    check("rst_data_out", data_out, 5'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].code, vecs[i].ok, vecs[i].syn, vecs[i].data, vecs[i].cnt, vecs[i].cnt2);
    end

    // Backpressure with in_valid pulses during SHIFT and DONE
    @(negedge clk);
    in_valid = 1'b1;
    code_in  = 37'h19_6ED82B7F;
    @(posedge clk);
    @(negedge clk);
    code_in = 37'h03_12345678;
    n = 0;
    while (n < 60) begin
      in_valid = n[0];
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
    check("bp_latency", 64'(n), 64'd37);
    check("bp_crc_ok", crc_ok, 1'b1);
    check("bp_data_out", data_out, 5'h19);
    syn_hold = syndrome; ok_hold = crc_ok; data_hold = data_out;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_syndrome_stable", syndrome, syn_hold);
      check("bp_ok_stable", crc_ok, ok_hold);
      check("bp_data_stable", data_out, data_hold);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_err_cnt", err_cnt, 16'd4);
    $display("txn backpressure ok=%0b syn=%h data=%h", crc_ok, syndrome, data_out);

    // Reset in the middle of SHIFT
    @(negedge clk);
    in_valid = 1'b1;
    code_in  = 37'h19_6ED82B7E;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_err_cnt", err_cnt, 16'd0);
    check("midrst_syndrome", syndrome, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_output", seen, 1'b0);
    $display("txn reset mid-shift err_cnt=%0d", err_cnt);
    send(37'h19_6ED82B7F, 1'b1, 32'h0, 5'h19, 16'd0, 2'd0);

    // Saturation of the 2-bit counter
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send(37'h19_6ED82B7E, 1'b0, 32'h1, 5'h19, 16'(k), (k >= 3) ? 2'd3 : 2'(k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_32_check.md
# crc_32_check

Serial CRC-32 checker that sits directly downstream of the CRC-32 generator and consumes its 37-bit codeword (5-bit data followed by 32-bit CRC). It divides the full codeword by the CRC-32 polynomial, one bit per clock, MSB first. It reports pass/fail, the 32-bit syndrome and the recovered data, and keeps a saturating error count. The polynomial arithmetic matches the generator: polynomial 0x04C11DB7, zero initial value, no bit reflection, no final XOR.

## Interface

Parameters:
- DATA_W, 5, payload width
- CRC_W, 32, CRC width
- POLY, 32'h04C11DB7, generator polynomial without the x^32 term
- CNT_W, 16, error counter width

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  codeword present on code_in
- in_ready  out  1  block can accept a codeword
- code_in  in  DATA_W+CRC_W  codeword as {data, crc}, MSB first
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- crc_ok  out  1  syndrome == 0
- syndrome  out  CRC_W  codeword mod POLY
- data_out  out  DATA_W  data field of the checked codeword
- err_cnt  out  CNT_W  count of failed checks; saturates

## Operation

- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready=1.
  - When in_valid=1: capture code_in into a shift register, clear the remainder register r and the bit counter, then go to SHIFT.
- **SHIFT**
  - Each cycle takes b = shift-register MSB and shifts the register left by 1.
  - If r[31]=1: r <= {r[30:0],b} ^ POLY. Otherwise: r <= {r[30:0],b}.
  - The bit counter increments each cycle. After the 37th bit (counter == DATA_W+CRC_W-1), go to DONE.
- **Entry to DONE**
  - Register syndrome = final r, crc_ok = (final r == 0), data_out = captured code_in[36:32].
  - If crc_ok=0, increment err_cnt. When err_cnt is all-ones it holds there (saturates).
- **DONE**
  - out_valid=1.
  - syndrome, crc_ok and data_out stay stable until the handshake completes.
  - When out_ready=1, go to IDLE.
- in_ready is 0 in SHIFT and DONE; in_valid is ignored in those states.
- Width rules:
  - r is exactly CRC_W bits; the carry out is r[31] before the shift.
  - The bit counter is $clog2(DATA_W+CRC_W) bits and never wraps in normal operation.

## Timing

- Reset (rst=0 at a rising edge), from any state:
  - state=IDLE; in_ready=1, out_valid=0, crc_ok=0, syndrome=0, data_out=0, err_cnt=0.
  - Any in-flight codeword is discarded with no output.
- Latency:
  - Accept edge = edge E0, where in_valid & in_ready.
  - out_valid rises after edge E0+37.
- Throughput: one codeword per 38 cycles plus the out_ready wait; out_ready held high gives 39 cycles per codeword.
- A codeword cannot be accepted in the same cycle its result is consumed.
- Outputs hold their last values in IDLE until the next DONE entry. out_valid is the only qualifier for them.
- err_cnt changes only on DONE entry.

## Structure

- Shared package crc_pkg:
  - CRC32_POLY constant
  - DATA_W/CRC_W defaults
  - chk_state_t enum {IDLE, SHIFT, DONE}
- The generator shares the same POLY constant from crc_pkg.
- One sub-module, crc_32_div_step: combinational single-bit division step (r, b -> r_next).
  - The generator reuses it later.
- Top-level code is the FSM, counter, shift register and output registers.

## Test plan

- Reset: hold rst=0 for 2 cycles, then release -> in_ready=1, out_valid=0, err_cnt=0, syndrome=0.
- Good codeword: code_in=37'h19_6ED82B7F (data 5'b11001) -> out_valid exactly 37 edges after accept, crc_ok=1, syndrome=0, data_out=5'b11001, err_cnt=0.
- Single-bit errors:
  - Flip bit 0 (37'h19_6ED82B7E) -> crc_ok=0, syndrome=32'h00000001, err_cnt=1.
  - Flip bit 32 (37'h18_6ED82B7F) -> syndrome=32'h04C11DB7, err_cnt=2.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
  - in_valid pulsed during SHIFT/DONE -> ignored.
  - out_ready=1 -> IDLE next cycle.
- Reset mid-SHIFT: assert rst=0 at bit 20 -> IDLE, no out_valid, err_cnt=0. The next good codeword checks clean.
- Saturation: CNT_W=2, send 5 corrupted codewords -> err_cnt sequence 1,2,3,3,3.
